// File: rtl/imem_load_arbiter_if.sv
// Fetch and loader bundle for imem_load_arbiter.
// master: the side that issues PC and drives the loader (IF stage plus loader).
// slave:  the instruction store itself.
interface imem_load_arbiter_if;
   logic [31:0] PC;
   logic [31:0] Instruction_Code;
   logic        stall;
   logic        fetch_fault;
   logic        ld_start;
   logic [31:0] ld_addr;
   logic [4:0]  ld_len;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_ready;
   logic        ld_done;
   logic        ld_error;

   modport master (
      output PC, ld_start, ld_addr, ld_len, ld_valid, ld_data,
      input  Instruction_Code, stall, fetch_fault, ld_ready, ld_done, ld_error
   );

   modport slave (
      input  PC, ld_start, ld_addr, ld_len, ld_valid, ld_data,
      output Instruction_Code, stall, fetch_fault, ld_ready, ld_done, ld_error
   );
endinterface

// File: rtl/imem_load_arbiter.sv
// Byte-wide instruction store shared between a combinational little-endian fetch port and a
// byte-serial loader. Fetch is stalled while a load session owns the store.
// Optional build macro IMEM_BOOT_IMAGE_EN: every reset reloads the factorial boot image and
// clears all other bytes; without it the store keeps its contents across reset.
module imem_load_arbiter #(
   parameter int unsigned DEPTH_BYTES = 64,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input logic                clk,
   input logic                reset,
   imem_load_arbiter_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

   state_e          state_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [6:0]      bytes_left_q;
   logic            done_q;
   logic            error_q;
   logic [7:0]      mem_q [DEPTH_BYTES];

   logic            mem_we;
   logic            pc_ok;
   logic            ld_addr_ok;
   logic [AW-1:0]   fidx;

   // Write only when the loader handshake completes inside a session, never under reset.
   assign mem_we     = reset && (state_q == StLoad) && bus.ld_valid;
   assign ld_addr_ok = (bus.ld_addr[1:0] == 2'b00) && (bus.ld_addr < 32'(DEPTH_BYTES));
   // Range check on the full PC so high garbage bits cannot alias into the store.
   assign pc_ok      = (bus.PC[1:0] == 2'b00) && (bus.PC <= 32'(DEPTH_BYTES - 4));
   assign fidx       = bus.PC[AW-1:0];

   assign bus.ld_ready = reset && (state_q == StLoad);
   assign bus.ld_done  = done_q;
   assign bus.ld_error = error_q;

   // Control FSM: session tracking with registered done pulse and sticky error.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         bytes_left_q <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.ld_start) begin
                  if (!ld_addr_ok) begin
                     error_q <= 1'b1;
                  end else if (bus.ld_len == 5'd0) begin
                     error_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end else begin
                     error_q      <= 1'b0;
                     wr_ptr_q     <= bus.ld_addr[AW-1:0];
                     bytes_left_q <= {bus.ld_len, 2'b00};
                     state_q      <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (bus.ld_valid) begin
                  // Pointer wraps naturally at AW bits; flag it but keep loading.
                  wr_ptr_q     <= wr_ptr_q + 1'b1;
                  bytes_left_q <= bytes_left_q - 7'd1;
                  if (&wr_ptr_q) error_q <= 1'b1;
                  if (bytes_left_q == 7'd1) begin
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end
               end
            end
            StFinish: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef IMEM_BOOT_IMAGE_EN
   localparam logic [7:0] BOOT_IMAGE [40] = '{
      8'h13, 8'h0E, 8'h40, 8'h00,  8'h93, 8'h0E, 8'h40, 8'h00,
      8'h93, 8'h02, 8'h10, 8'h00,  8'h13, 8'h03, 8'h20, 8'h00,
      8'h13, 8'h05, 8'h10, 8'h00,  8'h63, 8'h0A, 8'h0E, 8'h00,
      8'h33, 8'h0E, 8'h5E, 8'h40,  8'hB3, 8'h8E, 8'hCE, 8'h03,
      8'hE3, 8'h5C, 8'h6E, 8'hFE,  8'h23, 8'h20, 8'hD5, 8'h01
   };

   function automatic logic [7:0] boot_byte(input int unsigned i);
      logic [7:0] b;
      b = 8'h00;
      if (i < 40) b = BOOT_IMAGE[i[5:0]];
      return b;
   endfunction

   // Store: reset reloads the boot image, otherwise accept loader bytes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
            mem_q[i[AW-1:0]] <= boot_byte(i);
         end
      end else if (mem_we) begin
         mem_q[wr_ptr_q] <= bus.ld_data;
      end
   end
`else
   // Store: contents survive reset and change only through loader bytes.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= bus.ld_data;
   end
`endif

   // Fetch port: zero-latency little-endian read, NOP whenever not serviced or faulting.
   always_comb begin
      bus.Instruction_Code = NOP_WORD;
      bus.stall            = 1'b1;
      bus.fetch_fault      = 1'b0;
      if (reset && (state_q == StIdle)) begin
         bus.stall       = 1'b0;
         bus.fetch_fault = !pc_ok;
         if (pc_ok) begin
            bus.Instruction_Code = {mem_q[fidx + AW'(3)], mem_q[fidx + AW'(2)],
                                    mem_q[fidx + AW'(1)], mem_q[fidx]};
         end
      end
   end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: boot image (when built with IMEM_BOOT_IMAGE_EN),
// load, backpressure, wrap, fault and mid-session reset scenarios.
module tb_imem_load_arbiter;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [7:0] tb_bytes [8];

   imem_load_arbiter_if bus ();

   imem_load_arbiter #(
      .DEPTH_BYTES (64),
      .NOP_WORD    (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load session of len words from tb_bytes; optional idle gap before byte gap_at and
   // expected wrap on the write of byte wrap_at (-1 for none).
   task automatic run_load(input logic [31:0] addr, input logic [4:0] len, input int gap_at,
                           input int gap_len, input int wrap_at);
      int n;
      n = int'(len) * 4;
      bus.ld_addr  = addr;
      bus.ld_len   = len;
      bus.ld_start = 1'b1;
      bus.PC       = 32'd0;
      #1;
      check("start_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      bus.ld_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               bus.ld_valid = 1'b0;
               bus.ld_data  = 8'hFF;
               #1;
               check("gap_ready", {31'd0, bus.ld_ready}, 32'd1);
               check("gap_stall", {31'd0, bus.stall}, 32'd1);
               check("gap_done", {31'd0, bus.ld_done}, 32'd0);
               tick();
            end
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = tb_bytes[k];
         #1;
         check("load_ready", {31'd0, bus.ld_ready}, 32'd1);
         check("load_stall", {31'd0, bus.stall}, 32'd1);
         check("load_ic_nop", bus.Instruction_Code, NOP);
         check("load_error", {31'd0, bus.ld_error}, {31'd0, (wrap_at >= 0) && (k > wrap_at)});
         tick();
      end
      bus.ld_valid = 1'b0;
      #1;
      check("fin_done", {31'd0, bus.ld_done}, 32'd1);
      check("fin_stall", {31'd0, bus.stall}, 32'd1);
      check("fin_ready", {31'd0, bus.ld_ready}, 32'd0);
      check("fin_error", {31'd0, bus.ld_error}, {31'd0, wrap_at >= 0});
      tick();
      check("post_done", {31'd0, bus.ld_done}, 32'd0);
      check("post_stall", {31'd0, bus.stall}, 32'd0);
   endtask

   task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp_ic,
                        input logic exp_fault);
      bus.PC = pc;
      #1;
      check(tag, bus.Instruction_Code, exp_ic);
      check({tag, "_fault"}, {31'd0, bus.fetch_fault}, {31'd0, exp_fault});
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset        = 1'b0;
      bus.PC       = 32'd0;
      bus.ld_start = 1'b0;
      bus.ld_addr  = 32'd0;
      bus.ld_len   = 5'd0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = 8'h00;

      // Reset held low for two cycles.
      tick();
      tick();
      check("rst_stall", {31'd0, bus.stall}, 32'd1);
      check("rst_ic", bus.Instruction_Code, NOP);
      check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
      check("rst_ready", {31'd0, bus.ld_ready}, 32'd0);
      check("rst_done", {31'd0, bus.ld_done}, 32'd0);
      check("rst_error", {31'd0, bus.ld_error}, 32'd0);
      reset = 1'b1;
      #1;
      check("idle_stall", {31'd0, bus.stall}, 32'd0);

`ifdef IMEM_BOOT_IMAGE_EN
      fetch("boot_pc0", 32'd0, 32'h0040_0E13, 1'b0);
      fetch("boot_pc36", 32'd36, 32'h01D5_2023, 1'b0);
`endif

      // Plain load of two words at 40.
      tb_bytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h0E, 8'h5E, 8'h40};
      run_load(32'd40, 5'd2, -1, 0, -1);
      fetch("ld_pc40", 32'd40, 32'h0010_0513, 1'b0);
      fetch("ld_pc44", 32'd44, 32'h405E_0E33, 1'b0);

      // Same load with a three-cycle gap after byte 2.
      run_load(32'd40, 5'd2, 2, 3, -1);
      fetch("bp_pc40", 32'd40, 32'h0010_0513, 1'b0);
      fetch("bp_pc44", 32'd44, 32'h405E_0E33, 1'b0);

      // Wrap from byte 63 to byte 0.
      tb_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      run_load(32'd60, 5'd2, -1, 0, 3);
      fetch("wr_pc60", 32'd60, 32'hA4A3_A2A1, 1'b0);
      fetch("wr_pc0", 32'd0, 32'hB4B3_B2B1, 1'b0);
      check("wr_err_sticky", {31'd0, bus.ld_error}, 32'd1);

      // Zero-length session: accepted, clears error, done next cycle, no writes.
      bus.ld_addr  = 32'd0;
      bus.ld_len   = 5'd0;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("z_done", {31'd0, bus.ld_done}, 32'd1);
      check("z_err_clr", {31'd0, bus.ld_error}, 32'd0);
      check("z_ready", {31'd0, bus.ld_ready}, 32'd0);
      tick();
      check("z_done_end", {31'd0, bus.ld_done}, 32'd0);
      fetch("z_pc0", 32'd0, 32'hB4B3_B2B1, 1'b0);

      // Fetch faults at the range and alignment boundaries.
      fetch("f_pc2", 32'd2, NOP, 1'b1);
      fetch("f_pc64", 32'd64, NOP, 1'b1);
      fetch("f_pc61", 32'd61, NOP, 1'b1);
      fetch("f_hi", 32'h8000_0000, NOP, 1'b1);

      // Misaligned loader start is rejected and never enters LOAD.
      bus.ld_addr  = 32'd6;
      bus.ld_len   = 5'd1;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("rej_error", {31'd0, bus.ld_error}, 32'd1);
      check("rej_ready", {31'd0, bus.ld_ready}, 32'd0);
      check("rej_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      check("rej_done", {31'd0, bus.ld_done}, 32'd0);

      // Reset after three of four bytes.
      tb_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00};
      bus.ld_addr  = 32'd8;
      bus.ld_len   = 5'd1;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("mr_err_clr", {31'd0, bus.ld_error}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = tb_bytes[k];
         tick();
      end
      bus.ld_valid = 1'b0;
      reset        = 1'b0;
      #1;
      check("mr_rst_stall", {31'd0, bus.stall}, 32'd1);
      check("mr_rst_ready", {31'd0, bus.ld_ready}, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      check("mr_stall", {31'd0, bus.stall}, 32'd0);
      check("mr_ready", {31'd0, bus.ld_ready}, 32'd0);
      check("mr_done", {31'd0, bus.ld_done}, 32'd0);
      tick();
      check("mr_done2", {31'd0, bus.ld_done}, 32'd0);
      bus.PC = 32'd8;
      #1;
`ifdef IMEM_BOOT_IMAGE_EN
      check("mr_boot_pc8", bus.Instruction_Code, 32'h0010_0293);
`else
      check("mr_keep_pc8", bus.Instruction_Code & 32'h00FF_FFFF, 32'h00C3_C2C1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
